// File: rtl/vga_pkg.sv
// Shared VGA timing constants and pixel colour type for the display path.
package vga_pkg;

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned CNT_MAX      = 1024;

  // Default 640x480@60 timing (25 MHz pixel from a 50 MHz clk)
  localparam int unsigned CLK_DIV_DEF  = 2;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Colour answer produced by the sprite renderers
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // lo <= c < hi; one extra bit so hi may equal CNT_MAX
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input int unsigned lo,
                                     input int unsigned hi);
    logic [CNT_W:0] cx;
    cx = {1'b0, c};
    return (cx >= (CNT_W+1)'(lo)) && (cx < (CNT_W+1)'(hi));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: counts 0..TOTAL-1 on en, flags the wrap, decodes active and sync windows.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync_n
);

  localparam int unsigned      TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam int unsigned      SYNC_LO = ACTIVE + FP;
  localparam int unsigned      SYNC_HI = ACTIVE + FP + SYNC;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  // Next count: advance on en, wrap to zero after the last position
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign wrap   = en & at_last;
  assign active = in_window(cnt_q, 0, ACTIVE);
  assign sync_n = ~in_window(cnt_q, SYNC_LO, SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan source: pixel divider, H/V counters, registered sync/blank/colour to the ADV7123 DAC.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       r_data,
  input  logic [7:0]       g_data,
  input  logic [7:0]       b_data,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] y_cnt,
  output logic             pix_tick,
  output logic             frame_start,
  output logic             vga_clk,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_blank_n,
  output logic             vga_sync_n,
  output logic [7:0]       vga_r,
  output logic [7:0]       vga_g,
  output logic [7:0]       vga_b
);

  localparam int unsigned      H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned      V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned      DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  // Elaboration guards on the timing parameters
  if (H_TOT > CNT_MAX) begin : g_h_total_chk
    $error("vga_timing_gen: H total exceeds 10-bit counter range");
  end
  if (V_TOT > CNT_MAX) begin : g_v_total_chk
    $error("vga_timing_gen: V total exceeds 10-bit counter range");
  end
  if (CLK_DIV < 2) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_tick_q, pix_tick_d;
  logic             vga_clk_q, vga_clk_d;
  logic             frame_start_q, frame_start_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  rgb_t             rgb_q, rgb_d;
  rgb_t             rgb_in;

  logic h_wrap, h_active, h_sync_n;
  logic v_wrap, v_active, v_sync_n;
  logic unused_v_wrap;

  assign rgb_in        = '{r: r_data, g: g_data, b: b_data};
  assign unused_v_wrap = v_wrap;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .en     (pix_tick_q),
    .cnt    (x_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync_n (h_sync_n)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .en     (pix_tick_q & h_wrap),
    .cnt    (y_cnt),
    .wrap   (v_wrap),
    .active (v_active),
    .sync_n (v_sync_n)
  );

  // Next-state: divider phase, strobes, and the per-pixel output stage
  always_comb begin
    div_cnt_d     = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    pix_tick_d    = (div_cnt_d == DIV_LAST);
    vga_clk_d     = (div_cnt_d >= DIV_HALF);
    // Counters are stable whenever pix_tick_d rises, so current (0,0) is the next pixel
    frame_start_d = pix_tick_d && (x_cnt == '0) && (y_cnt == '0);
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    if (pix_tick_q) begin
      hs_d      = h_sync_n;
      vs_d      = v_sync_n;
      blank_n_d = h_active & v_active;
      rgb_d     = (h_active && v_active) ? rgb_in : '0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      pix_tick_q    <= 1'b0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_tick_q    <= pix_tick_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign frame_start = frame_start_q;
  assign vga_clk     = vga_clk_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a reduced-timing instance is scanned pixel by pixel; a default-timing instance checks one real line.
module tb_vga_timing_gen;

  // Reduced timing: 15 pixels x 8 lines, hsync x=10..12, vsync y=5..6
  localparam int SH_A = 8, SH_FP = 2, SH_S = 3, SH_BP = 2, SH_T = 15;
  localparam int SV_A = 4, SV_FP = 1, SV_S = 2, SV_BP = 1, SV_T = 8;
  localparam int NTBL = 13;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] r_data = '0, g_data = '0, b_data = '0;

  logic [9:0] x_cnt, y_cnt;
  logic       pix_tick, frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0] vga_r, vga_g, vga_b;

  logic [9:0] d_x, d_y;
  logic       d_pix_tick, d_frame_start, d_vga_clk, d_hs, d_vs, d_blank_n, d_sync_n;
  logic [7:0] d_r, d_g, d_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         px;
    int         py;
    logic [7:0] r, g, b;
    logic       hs, vs, bl;
    logic [7:0] er, eg, eb;
  } vec_t;

  vec_t tbl [NTBL];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
    .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP)
  ) dut (
    .clk(clk), .rst(rst), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .pix_tick(pix_tick), .frame_start(frame_start),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst(rst), .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .x_cnt(d_x), .y_cnt(d_y), .pix_tick(d_pix_tick), .frame_start(d_frame_start),
    .vga_clk(d_vga_clk), .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_blank_n),
    .vga_sync_n(d_sync_n), .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_small_reset();
    chk("rst x_cnt", 32'(x_cnt), 0);
    chk("rst y_cnt", 32'(y_cnt), 0);
    chk("rst pix_tick", 32'(pix_tick), 0);
    chk("rst frame_start", 32'(frame_start), 0);
    chk("rst vga_clk", 32'(vga_clk), 0);
    chk("rst vga_hs", 32'(vga_hs), 1);
    chk("rst vga_vs", 32'(vga_vs), 1);
    chk("rst blank_n", 32'(vga_blank_n), 0);
    chk("rst sync_n", 32'(vga_sync_n), 0);
    chk("rst rgb", 32'({vga_r, vga_g, vga_b}), 0);
  endtask

  task automatic chk_def_reset();
    chk("d rst x", 32'(d_x), 0);
    chk("d rst y", 32'(d_y), 0);
    chk("d rst pix_tick", 32'(d_pix_tick), 0);
    chk("d rst frame_start", 32'(d_frame_start), 0);
    chk("d rst vga_clk", 32'(d_vga_clk), 0);
    chk("d rst hs", 32'(d_hs), 1);
    chk("d rst vs", 32'(d_vs), 1);
    chk("d rst blank_n", 32'(d_blank_n), 0);
    chk("d rst sync_n", 32'(d_sync_n), 0);
    chk("d rst rgb", 32'({d_r, d_g, d_b}), 0);
  endtask

  // Safety net against a stalled run
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex, ey, ti, cur_idx, prev_idx, prev_x, prev_y;
    logic [7:0] prev_r, prev_g, prev_b;
    logic exp_act, exp_hs, exp_vs;
    logic [7:0] exp_r, exp_g, exp_b;
    bit found;
    int hs_low, first_low, last_low, bl_cnt, vs_low, red_cnt;

    // px, py, r, g, b, hs, vs, blank_n, exp r/g/b (hand-computed for the reduced timing)
    tbl[0]  = '{0,  0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF};
    tbl[1]  = '{7,  0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33};
    tbl[2]  = '{8,  0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{10, 0, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{12, 1, 8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{13, 1, 8'h44, 8'h55, 8'h66, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[6]  = '{7,  3, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56};
    tbl[7]  = '{14, 3, 8'h77, 8'h88, 8'h99, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[8]  = '{0,  4, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[9]  = '{3,  5, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[10] = '{11, 6, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[11] = '{3,  7, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{14, 7, 8'h9A, 8'hBC, 8'hDE, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};

    // Reset for 10 clks
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk_small_reset();
    rst = 1'b0;
    @(negedge clk);

    // Pixel-by-pixel scan: just over two frames
    ti = 0; prev_idx = -1; prev_x = 0; prev_y = 0;
    prev_r = '0; prev_g = '0; prev_b = '0;
    for (int p = 0; p < 250; p++) begin
      ex = p % SH_T;
      ey = (p / SH_T) % SV_T;
      chk("x_cnt", 32'(x_cnt), 32'(ex));
      chk("y_cnt", 32'(y_cnt), 32'(ey));
      chk("pix_tick", 32'(pix_tick), 1);
      chk("vga_clk hi", 32'(vga_clk), 1);
      chk("frame_start", 32'(frame_start), 32'(ex == 0 && ey == 0));
      if (p > 0) begin
        if (prev_idx >= 0) begin
          exp_hs = tbl[prev_idx].hs; exp_vs = tbl[prev_idx].vs; exp_act = tbl[prev_idx].bl;
          exp_r = tbl[prev_idx].er; exp_g = tbl[prev_idx].eg; exp_b = tbl[prev_idx].eb;
        end else begin
          exp_act = (prev_x < SH_A) && (prev_y < SV_A);
          exp_hs  = !((prev_x >= 10) && (prev_x < 13));
          exp_vs  = !((prev_y >= 5) && (prev_y < 7));
          exp_r   = exp_act ? prev_r : 8'h00;
          exp_g   = exp_act ? prev_g : 8'h00;
          exp_b   = exp_act ? prev_b : 8'h00;
        end
        chk("vga_hs", 32'(vga_hs), 32'(exp_hs));
        chk("vga_vs", 32'(vga_vs), 32'(exp_vs));
        chk("vga_blank_n", 32'(vga_blank_n), 32'(exp_act));
        chk("vga_r", 32'(vga_r), 32'(exp_r));
        chk("vga_g", 32'(vga_g), 32'(exp_g));
        chk("vga_b", 32'(vga_b), 32'(exp_b));
      end
      cur_idx = -1;
      if (p < SH_T * SV_T && ti < NTBL && tbl[ti].px == ex && tbl[ti].py == ey) begin
        cur_idx = ti;
        ti++;
        r_data = tbl[cur_idx].r; g_data = tbl[cur_idx].g; b_data = tbl[cur_idx].b;
      end else begin
        r_data = 8'(ex); g_data = 8'hC3; b_data = 8'(ey + 8'h40);
      end
      prev_idx = cur_idx; prev_x = ex; prev_y = ey;
      prev_r = r_data; prev_g = g_data; prev_b = b_data;
      @(negedge clk);
      chk("pix_tick gap", 32'(pix_tick), 0);
      chk("vga_clk lo", 32'(vga_clk), 0);
      chk("frame_start gap", 32'(frame_start), 0);
      @(negedge clk);
    end
    chk("table entries used", 32'(ti), 32'(NTBL));

    // Mid-frame reset at (5,2)
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (pix_tick && x_cnt == 10'd5 && y_cnt == 10'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach (5,2)", 32'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_small_reset();
    chk_def_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("restart x", 32'(x_cnt), 0);
    chk("restart y", 32'(y_cnt), 0);
    chk("restart pix_tick", 32'(pix_tick), 1);
    chk("restart frame_start", 32'(frame_start), 1);
    for (int k = 1; k <= SH_T * SV_T; k++) begin
      @(negedge clk);
      @(negedge clk);
      chk("restart tick", 32'(pix_tick), 1);
      chk("restart frame_start spacing", 32'(frame_start), 32'(k == SH_T * SV_T));
    end

    // Default 640x480 timing: one full line
    rst = 1'b1;
    r_data = 8'h80; g_data = 8'h00; b_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_def_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("d first tick", 32'(d_pix_tick), 1);
    chk("d first frame_start", 32'(d_frame_start), 1);
    hs_low = 0; first_low = -1; last_low = -1; bl_cnt = 0; vs_low = 0; red_cnt = 0;
    for (int t = 1; t <= 800; t++) begin
      @(negedge clk);
      @(negedge clk);
      if (!d_pix_tick) chk("d tick period", 32'(d_pix_tick), 1);
      if (!d_hs) begin
        hs_low++;
        if (first_low < 0) first_low = t;
        last_low = t;
      end
      if (!d_vs) vs_low++;
      if (d_blank_n) bl_cnt++;
      if (d_r == 8'h80 && d_blank_n) red_cnt++;
      if (t == 799) chk("d x at 799", 32'(d_x), 799);
      if (t == 800) begin
        chk("d x wrap", 32'(d_x), 0);
        chk("d y step", 32'(d_y), 1);
      end
    end
    chk("d hs low count", 32'(hs_low), 96);
    chk("d hs first low tick", 32'(first_low), 657);
    chk("d hs last low tick", 32'(last_low), 752);
    chk("d vs low on line 0", 32'(vs_low), 0);
    chk("d blank_n count", 32'(bl_cnt), 640);
    chk("d red count", 32'(red_cnt), 640);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
